// File: rtl/ram_unit_if.sv
// Control and address group for the data RAM. The shared data bus is a
// plain inout port on ram_unit so tri-state resolution stays at module level.
interface ram_unit_if #(
    parameter int address_width = 8
);
    logic                     wr_en;
    logic                     rd_en;
    logic                     ram_enable;
    logic [address_width-1:0] address_bus;

    modport master (
        output wr_en,
        output rd_en,
        output ram_enable,
        output address_bus
    );

    modport slave (
        input wr_en,
        input rd_en,
        input ram_enable,
        input address_bus
    );
endinterface

// File: rtl/ram_unit.sv
// Processor data memory: synchronous write, combinational read onto a shared
// tri-state bus, asynchronous active-high clear of the whole array.
module ram_unit #(
    parameter int address_width = 8,
    parameter int data_width    = 8,
    parameter int ram_size      = 1 << address_width
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_unit_if.slave             bus,
    inout  wire  [data_width-1:0] data_bus,
    output logic                  bus_drive
);

    logic [data_width-1:0] mem_q [ram_size];
    logic [data_width-1:0] mem_d [ram_size];
    logic                  wr_fire;

    // Handshake: the bus belongs to the RAM only while selected (ram_enable=0),
    // reading (rd_en=1), not writing (wr_en=0) and out of reset; a write always
    // wins over a read so the RAM never fights the external writer.
    always_comb begin
        wr_fire   = !bus.ram_enable && bus.wr_en;
        bus_drive = !reset && !bus.ram_enable && bus.rd_en && !bus.wr_en;
        mem_d     = mem_q;
        if (wr_fire) begin
            mem_d[bus.address_bus] = data_bus;
        end
    end

    assign data_bus = bus_drive ? mem_q[bus.address_bus] : {data_width{1'bz}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_ram_unit.sv
// Directed bench for ram_unit: reset clear, sequential fill, deselect,
// write/read priority, combinational read and asynchronous reset mid-write.
module tb_ram_unit;

    logic       clock;
    logic       reset;
    wire  [7:0] data_bus;
    logic       bus_drive;
    logic       tb_drv_en;
    logic [7:0] tb_drv_data;
    int         checks;
    int         errors;

    ram_unit_if #(.address_width(8)) bus_if ();

    assign data_bus = tb_drv_en ? tb_drv_data : 8'hzz;

    ram_unit #(
        .address_width(8),
        .data_width(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus_if.slave),
        .data_bus(data_bus),
        .bus_drive(bus_drive)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        bus_if.ram_enable  = 1'b0;
        bus_if.wr_en       = 1'b1;
        bus_if.rd_en       = 1'b0;
        bus_if.address_bus = a;
        tb_drv_data        = d;
        tb_drv_en          = 1'b1;
        @(posedge clock);
        #1;
        bus_if.wr_en = 1'b0;
        tb_drv_en    = 1'b0;
    endtask

    task automatic start_read(input logic [7:0] a);
        @(negedge clock);
        tb_drv_en          = 1'b0;
        bus_if.wr_en       = 1'b0;
        bus_if.ram_enable  = 1'b0;
        bus_if.rd_en       = 1'b1;
        bus_if.address_bus = a;
        #1;
    endtask

    task automatic test_reset;
        reset              = 1'b1;
        tb_drv_en          = 1'b0;
        tb_drv_data        = 8'h00;
        bus_if.ram_enable  = 1'b0;
        bus_if.rd_en       = 1'b1;
        bus_if.wr_en       = 1'b0;
        bus_if.address_bus = 8'h00;
        #12;
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus_release: bus_drive=%b expected 0", bus_drive);
        end
        @(negedge clock);
        reset = 1'b0;
        start_read(8'h00);
        checks++;
        if (data_bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial_zero: data=%h expected 00", data_bus);
        end
        write_word(8'h03, 8'hA5);
        start_read(8'h03);
        checks++;
        if (data_bus !== 8'hA5) begin
            errors++;
            $display("FAIL reset_pre_write: data=%h expected a5", data_bus);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_selected: bus_drive=%b expected 0", bus_drive);
        end
        @(negedge clock);
        reset = 1'b0;
        start_read(8'h03);
        checks++;
        if (data_bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear: data=%h expected 00", data_bus);
        end
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i), 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            start_read(8'(i));
            checks++;
            if (bus_drive !== 1'b1 || data_bus !== 8'(i)) begin
                errors++;
                $display("FAIL seq_read[%0d]: drive=%b data=%h expected 1/%h",
                         i, bus_drive, data_bus, 8'(i));
            end
        end
    endtask

    task automatic test_deselect;
        @(negedge clock);
        bus_if.ram_enable  = 1'b1;
        bus_if.wr_en       = 1'b1;
        bus_if.rd_en       = 1'b0;
        bus_if.address_bus = 8'h05;
        tb_drv_data        = 8'h3C;
        tb_drv_en          = 1'b1;
        @(posedge clock);
        #1;
        bus_if.wr_en = 1'b0;
        tb_drv_en    = 1'b0;
        start_read(8'h05);
        checks++;
        if (data_bus !== 8'h05) begin
            errors++;
            $display("FAIL deselect_no_write: data=%h expected 05", data_bus);
        end
        bus_if.ram_enable = 1'b1;
        #1;
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL deselect_bus_release: bus_drive=%b expected 0", bus_drive);
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clock);
        bus_if.ram_enable  = 1'b0;
        bus_if.wr_en       = 1'b1;
        bus_if.rd_en       = 1'b1;
        bus_if.address_bus = 8'h09;
        tb_drv_data        = 8'h77;
        tb_drv_en          = 1'b1;
        #1;
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL simul_no_contention: bus_drive=%b expected 0", bus_drive);
        end
        @(posedge clock);
        #1;
        bus_if.wr_en = 1'b0;
        tb_drv_en    = 1'b0;
        start_read(8'h09);
        checks++;
        if (data_bus !== 8'h77) begin
            errors++;
            $display("FAIL simul_write_wins: data=%h expected 77", data_bus);
        end
    endtask

    task automatic test_comb_read;
        start_read(8'h02);
        checks++;
        if (data_bus !== 8'h02) begin
            errors++;
            $display("FAIL comb_read_addr2: data=%h expected 02", data_bus);
        end
        bus_if.address_bus = 8'h07;
        #1;
        checks++;
        if (data_bus !== 8'h07) begin
            errors++;
            $display("FAIL comb_read_addr7: data=%h expected 07", data_bus);
        end
    endtask

    task automatic test_async_reset_mid_write;
        for (int i = 0; i < 4; i++) begin
            write_word(8'(20 + i), 8'(8'h90 + i));
        end
        start_read(8'd20);
        checks++;
        if (data_bus !== 8'h90) begin
            errors++;
            $display("FAIL midreset_pre: data=%h expected 90", data_bus);
        end
        // Reset lands between edges, then a write straddles the next edge.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus_drive !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bus_release: bus_drive=%b expected 0", bus_drive);
        end
        bus_if.rd_en       = 1'b0;
        bus_if.wr_en       = 1'b1;
        bus_if.address_bus = 8'd24;
        tb_drv_data        = 8'hEE;
        tb_drv_en          = 1'b1;
        @(posedge clock);
        #1;
        bus_if.wr_en = 1'b0;
        tb_drv_en    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_read(8'(20 + i));
            checks++;
            if (data_bus !== 8'h00) begin
                errors++;
                $display("FAIL midreset_clear[%0d]: data=%h expected 00", 20 + i, data_bus);
            end
        end
        start_read(8'h07);
        checks++;
        if (data_bus !== 8'h00) begin
            errors++;
            $display("FAIL midreset_clear_old: data=%h expected 00", data_bus);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_deselect();
        test_simultaneous();
        test_comb_read();
        test_async_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
